// File: rtl/rvb3_pkg.sv
// Shared types for the rvb3 memory arbiter slice:
// default widths, sequencer states and requester ids.
package rvb3_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_e;

  typedef enum logic {
    REQ_F,
    REQ_L
  } req_e;

endpackage

// File: rtl/rvb3_arb_prio.sv
// Winner select: LSU has priority unless fetch is starved.
// Ports: f_valid/l_valid/starve_hit in, f_gnt/l_gnt out.
module rvb3_arb_prio (
  input  logic f_valid,
  input  logic l_valid,
  input  logic starve_hit,
  output logic f_gnt,
  output logic l_gnt
);

  always_comb begin
    l_gnt = l_valid & ~(f_valid & starve_hit);
    f_gnt = f_valid & ~l_gnt;
  end

endmodule

// File: rtl/rvb3_mem_arbiter.sv
// Shares one fixed-latency memory port between fetch and LSU.
// Ports: F/L valid-ready requests, rsp pulses, mem_* strobe, busy.
module rvb3_mem_arbiter
  import rvb3_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_valid,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ready,
  input  logic              l_valid,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_ready,
  output logic              f_rsp_valid,
  output logic              l_rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [3:0] LAT  = 4'(MEM_LAT);
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  state_e            state_q, state_d;
  req_e              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [3:0]        lat_q, lat_d;
  logic [3:0]        starve_q, starve_d;
  logic              f_rsp_q, f_rsp_d;
  logic              l_rsp_q, l_rsp_d;
  logic              f_gnt, l_gnt;

  rvb3_arb_prio u_prio (
    .f_valid    (f_valid),
    .l_valid    (l_valid),
    .starve_hit (starve_q == SMAX),
    .f_gnt      (f_gnt),
    .l_gnt      (l_gnt)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    lat_d    = lat_q;
    starve_d = starve_q;
    f_rsp_d  = 1'b0;
    l_rsp_d  = 1'b0;
    f_ready  = 1'b0;
    l_ready  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Ready is masked while reset is held.
        f_ready = rst & f_gnt;
        l_ready = rst & l_gnt;
        if (l_ready) begin
          owner_d = REQ_L;
          we_d    = l_we;
          addr_d  = l_addr;
          wdata_d = l_wdata;
          state_d = ISSUE;
          if (f_valid && starve_q != SMAX)
            starve_d = starve_q + 4'd1;
        end else if (f_ready) begin
          owner_d  = REQ_F;
          we_d     = 1'b0;
          addr_d   = f_addr;
          state_d  = ISSUE;
          starve_d = 4'd0;
        end
      end
      ISSUE: begin
        lat_d   = LAT;
        state_d = WAIT;
      end
      WAIT: begin
        lat_d = lat_q - 4'd1;
        if (lat_q == 4'd1) begin
          state_d = IDLE;
          rdata_d = we_q ? '0 : mem_rdata;
          f_rsp_d = (owner_q == REQ_F);
          l_rsp_d = (owner_q == REQ_L);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      owner_q  <= REQ_F;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      lat_q    <= '0;
      starve_q <= '0;
      f_rsp_q  <= 1'b0;
      l_rsp_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      lat_q    <= lat_d;
      starve_q <= starve_d;
      f_rsp_q  <= f_rsp_d;
      l_rsp_q  <= l_rsp_d;
    end
  end

  assign mem_en      = (state_q == ISSUE);
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign busy        = (state_q != IDLE);
  assign f_rsp_valid = f_rsp_q;
  assign l_rsp_valid = l_rsp_q;
  assign rsp_rdata   = rdata_q;

endmodule

// File: tb/tb_rvb3_mem_arbiter.sv
// Directed bench for rvb3_mem_arbiter with a fixed-latency
// memory model that drives 0xEE outside the valid data cycle.
module tb_rvb3_mem_arbiter;

  localparam int MEM_LAT = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       f_valid = 1'b0, l_valid = 1'b0, l_we = 1'b0;
  logic [7:0] f_addr = '0, l_addr = '0, l_wdata = '0;
  logic       f_ready, l_ready, f_rsp, l_rsp;
  logic [7:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic       mem_en, mem_we, busy;

  logic [7:0] mem_arr [256];
  logic [3:0] rd_cnt = '0;
  logic [7:0] rd_addr = '0;

  int n_cmp = 0;
  int n_bad = 0;
  logic prev_f;
  logic exp_f;

  always #5 clk = ~clk;

  rvb3_mem_arbiter #(
    .ADDR_W(8), .DATA_W(8), .MEM_LAT(MEM_LAT), .STARVE_MAX(3)
  ) dut (
    .clk(clk), .rst(rst),
    .f_valid(f_valid), .f_addr(f_addr), .f_ready(f_ready),
    .l_valid(l_valid), .l_we(l_we), .l_addr(l_addr),
    .l_wdata(l_wdata), .l_ready(l_ready),
    .f_rsp_valid(f_rsp), .l_rsp_valid(l_rsp),
    .rsp_rdata(rsp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always @(posedge clk) begin
    if (mem_en && !mem_we) begin
      rd_cnt  <= 4'(MEM_LAT);
      rd_addr <= mem_addr;
    end else if (rd_cnt != 0) begin
      rd_cnt <= rd_cnt - 4'd1;
    end
  end

  assign mem_rdata = (rd_cnt == 4'd1) ? mem_arr[rd_addr] : 8'hEE;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = 8'(i);
    mem_arr[8'h10] = 8'hA5;
    mem_arr[8'h30] = 8'h5A;
    mem_arr[8'h70] = 8'h11;
    mem_arr[8'h71] = 8'h22;
    mem_arr[8'h50] = 8'h77;
    mem_arr[8'h60] = 8'h99;

    // reset held while valids toggle
    tick(); tick();
    f_valid = 1'b1; l_valid = 1'b1; #1;
    chk("rst_ctl", {f_ready, l_ready, f_rsp, l_rsp,
                    mem_en, mem_we, busy}, 0);
    chk("rst_dat", {rsp_rdata, mem_addr, mem_wdata}, 0);
    tick();
    f_valid = 1'b0; #1;
    chk("rst_rdy", {f_ready, l_ready}, 0);

    // release; fetch accepted in the same cycle (T)
    tick();
    l_valid = 1'b0; f_valid = 1'b1; f_addr = 8'h10; rst = 1'b1; #1;
    chk("f_acc", {f_ready, l_ready}, 2'b10);
    tick();
    f_valid = 1'b0; #1;
    chk("f_iss", {mem_en, mem_we, busy, f_ready}, 4'b1010);
    chk("f_iss_a", mem_addr, 8'h10);
    tick(); #1;
    chk("f_w2", {mem_en, busy, f_rsp, l_rsp}, 4'b0100);
    tick(); #1;
    chk("f_w3", {mem_en, busy, f_rsp, l_rsp}, 4'b0100);
    tick(); #1;
    chk("f_rsp", {f_rsp, l_rsp, busy}, 3'b100);
    chk("f_data", rsp_rdata, 8'hA5);
    tick(); #1;
    chk("f_hold", {f_rsp, l_rsp, busy}, 0);
    chk("f_hold_d", rsp_rdata, 8'hA5);

    // simultaneous: LSU write wins, fetch taken in L's rsp cycle
    l_valid = 1'b1; l_we = 1'b1; l_addr = 8'h20; l_wdata = 8'h3C;
    f_valid = 1'b1; f_addr = 8'h30; #1;
    chk("sim_rdy", {f_ready, l_ready}, 2'b01);
    tick();
    l_valid = 1'b0; l_we = 1'b0; #1;
    chk("wr_iss", {mem_en, mem_we, f_ready}, 3'b110);
    chk("wr_a", {mem_addr, mem_wdata}, {8'h20, 8'h3C});
    tick(); #1;
    tick(); #1;
    chk("sim_wait", {f_ready, l_ready, l_rsp}, 0);
    tick(); #1;
    chk("wr_rsp", {l_rsp, f_rsp, f_ready, busy}, 4'b1010);
    chk("wr_data", rsp_rdata, 8'h00);
    tick();
    f_valid = 1'b0; #1;
    chk("f2_iss", {mem_en, mem_we}, 2'b10);
    chk("f2_a", mem_addr, 8'h30);
    tick(); tick(); tick(); #1;
    chk("f2_rsp", {f_rsp, l_rsp}, 2'b10);
    chk("f2_data", rsp_rdata, 8'h5A);

    // starvation guard: L,L,L,F,L,L,L,F
    f_valid = 1'b1; l_valid = 1'b1; l_we = 1'b0;
    f_addr = 8'h70; l_addr = 8'h71;
    prev_f = 1'b0;
    for (int g = 0; g < 8; g++) begin
      #1;
      exp_f = (g % 4 == 3);
      chk($sformatf("grant%0d", g), {f_ready, l_ready},
          exp_f ? 2'b10 : 2'b01);
      if (g > 0)
        chk($sformatf("srsp%0d", g), {f_rsp, l_rsp, rsp_rdata},
            prev_f ? {2'b10, 8'h11} : {2'b01, 8'h22});
      prev_f = exp_f;
      repeat (4) tick();
    end
    f_valid = 1'b0; l_valid = 1'b0; #1;
    chk("srsp8", {f_rsp, l_rsp, rsp_rdata}, {2'b10, 8'h11});

    // reset in the middle of a fetch
    tick();
    f_valid = 1'b1; f_addr = 8'h50; #1;
    chk("mr_acc", f_ready, 1'b1);
    tick();
    f_valid = 1'b0; #1;
    tick();
    rst = 1'b0; #1;
    chk("mr_ctl", {mem_en, busy, f_rsp, l_rsp, f_ready}, 0);
    chk("mr_dat", rsp_rdata, 8'h00);
    tick(); #1;
    chk("mr_nrsp3", {f_rsp, busy}, 0);
    tick(); #1;
    chk("mr_nrsp4", {f_rsp, busy}, 0);
    rst = 1'b1; f_valid = 1'b1; f_addr = 8'h60; #1;
    chk("mr_acc2", {f_ready, l_ready}, 2'b10);
    tick();
    f_valid = 1'b0; #1;
    chk("mr_iss", {mem_en, mem_we, busy}, 3'b101);
    chk("mr_a", mem_addr, 8'h60);
    tick(); #1;
    chk("mr_w", {f_rsp, busy}, 2'b01);
    tick(); tick(); #1;
    chk("mr_rsp", {f_rsp, l_rsp, busy}, 3'b100);
    chk("mr_data", rsp_rdata, 8'h99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rvb3_mem_arbiter.md
Name: rvb3_mem_arbiter

Overview:
Sequencer and arbiter that shares the single-port memory of the diferential_rvb3 RISC-V core between two requesters: instruction fetch (F) and load/store unit (L).
- Accepts one request at a time over valid/ready.
- Drives a fixed-latency memory.
- Returns the response to the owning requester.
- LSU has fixed priority, with a starvation guard for fetch.
- Sits between the core pipeline and the memory macro inside the top-level block.

Parameters:
ADDR_W, 8, address width (bits)
DATA_W, 8, data width (bits)
MEM_LAT, 2, cycles from mem_en to valid mem_rdata; legal range 1..15
STARVE_MAX, 3, consecutive LSU wins while F is pending before F is forced to win; range 1..15

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
f_valid  in  1  fetch request valid
f_addr  in  ADDR_W  fetch address
f_ready  out  1  fetch request accepted this cycle
l_valid  in  1  LSU request valid
l_we  in  1  LSU write enable
l_addr  in  ADDR_W  LSU address
l_wdata  in  DATA_W  LSU write data
l_ready  out  1  LSU request accepted this cycle
f_rsp_valid  out  1  fetch response, 1-cycle pulse
l_rsp_valid  out  1  LSU response, 1-cycle pulse
rsp_rdata  out  DATA_W  response data, valid with either rsp pulse
mem_en  out  1  memory access strobe, 1 cycle
mem_we  out  1  memory write
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
busy  out  1  transaction in flight

Behaviour:
- Reset (rst=0, async):
  - All outputs 0; state IDLE; starve_cnt 0.
  - Any in-flight transaction is dropped with no response.
- State machine has three states: IDLE, ISSUE, WAIT.
- IDLE:
  - f_ready and l_ready are combinational; at most one is high per cycle.
  - Winner is L if l_valid, unless f_valid and starve_cnt==STARVE_MAX; otherwise F if f_valid.
  - On handshake (valid & ready) in cycle T: latch addr, we (0 for F), wdata and owner; go to ISSUE.
- ISSUE (cycle T+1):
  - mem_en=1; mem_addr, mem_we, mem_wdata driven from latches.
  - Load lat_cnt=MEM_LAT; go to WAIT. busy=1.
- WAIT:
  - Decrement lat_cnt each cycle.
  - mem_rdata is sampled at the end of cycle T+1+MEM_LAT.
  - In cycle T+2+MEM_LAT: the owner's rsp_valid=1 and rsp_rdata holds the sampled data (0x00 for writes).
  - State is IDLE in that same cycle, so a new handshake may occur in the response cycle.
  - Throughput: one transaction per MEM_LAT+2 cycles.
- Outputs outside the pulse cycles:
  - rsp_rdata holds its last value; both rsp_valid pulses are 0.
  - mem_en is 0 outside ISSUE; mem_addr, mem_we and mem_wdata hold their last values; mem_we is only meaningful with mem_en.
- busy is 1 from T+1 through T+1+MEM_LAT, and 0 in the response cycle.
- Starvation counter (starve_cnt):
  - +1 when L wins while f_valid=1; saturates at STARVE_MAX.
  - Cleared when F wins.
  - Unchanged when L wins with f_valid=0.
- Requesters must hold valid and payload stable until ready. The arbiter ignores valid outside IDLE, and ready stays 0 there.
- Simultaneous rsp pulse and new accept: both happen in the same cycle with no conflict. The owner updates only at the accept.

Decomposition:
- Package rvb3_pkg:
  - ADDR_W / DATA_W defaults.
  - State enum {IDLE, ISSUE, WAIT}.
  - Requester id enum {REQ_F, REQ_L}.
- Sub-module rvb3_arb_prio: combinational winner select from f_valid, l_valid, and starve_cnt==STARVE_MAX. The counter itself stays in the parent.

Test Plan:
- Reset: hold rst=0 while toggling valids -> all outputs 0; release -> first f_valid is accepted in the same cycle.
- Fetch read, MEM_LAT=2, f_addr=0x10, memory returns 0xA5 -> f_ready at T; mem_en=1, mem_addr=0x10, mem_we=0 at T+1; f_rsp_valid=1, rsp_rdata=0xA5 at T+4; l_rsp_valid=0 throughout.
- Simultaneous f_valid and l_valid in IDLE -> l_ready=1, f_ready=0. F is accepted in the response cycle of L (T+4).
- Starvation, STARVE_MAX=3, both valid continuously -> grant order L, L, L, F, L, L, L, F; starve_cnt returns to 0 after each F win.
- LSU write, l_we=1, l_addr=0x20, l_wdata=0x3C -> at T+1 mem_en=1, mem_we=1, mem_addr=0x20, mem_wdata=0x3C; at T+4 l_rsp_valid=1 and rsp_rdata=0x00.
- Reset mid-operation: rst=0 at T+2 of a fetch -> outputs 0 immediately and no f_rsp_valid ever; after release, a new fetch completes with normal T+4 timing.
